// File: rtl/cu_pkg.sv
// Shared decode constants and types for the control unit.
// Opcodes, ALU operation codes and datapath select encodings.
package cu_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'b00000,
    ALU_SUB    = 5'b00001,
    ALU_AND    = 5'b00010,
    ALU_OR     = 5'b00011,
    ALU_XOR    = 5'b00100,
    ALU_SLT    = 5'b00101,
    ALU_SLTU   = 5'b00110,
    ALU_SLL    = 5'b00111,
    ALU_SRL    = 5'b01000,
    ALU_SRA    = 5'b01001,
    ALU_PASS_B = 5'b01010
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_TARGET = 2'b01,
    PC_ALU    = 2'b10
  } pc_src_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } res_src_t;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_t;

  typedef enum logic [2:0] {
    CLS_ADD,
    CLS_R,
    CLS_I,
    CLS_BR,
    CLS_PASS
  } alu_cls_t;

  typedef struct packed {
    pc_src_t  pcsrc;
    res_src_t resultsrc;
    logic     memwrite;
    logic     alusrc;
    logic     regwrite;
    imm_src_t immsrc;
  } ctrl_t;

  localparam ctrl_t CTRL_DEF = '{
    pcsrc:     PC_PLUS4,
    resultsrc: RES_ALU,
    memwrite:  1'b0,
    alusrc:    1'b0,
    regwrite:  1'b0,
    immsrc:    IMM_I
  };

endpackage

// File: rtl/control_unit_alu_decoder.sv
// ALU decoder: instruction class plus funct fields to ALU operation.
// Also flags funct7/funct3 combinations that have no encoding.
module alu_decoder
  import cu_pkg::*;
(
  input  alu_cls_t   cls,
  input  logic [2:0] f3,
  input  logic [6:0] f7,
  output alu_op_t    alu,
  output logic       illegal
);

  logic    alt;
  logic    base;
  alu_op_t fmap;

  assign alt  = (f7 == F7_ALT);
  assign base = (f7 == F7_BASE);

  always_comb begin
    fmap = ALU_ADD;
    unique case (f3)
      3'b000: fmap = (cls == CLS_R && alt) ? ALU_SUB : ALU_ADD;
      3'b001: fmap = ALU_SLL;
      3'b010: fmap = ALU_SLT;
      3'b011: fmap = ALU_SLTU;
      3'b100: fmap = ALU_XOR;
      3'b101: fmap = alt ? ALU_SRA : ALU_SRL;
      3'b110: fmap = ALU_OR;
      3'b111: fmap = ALU_AND;
      default: fmap = ALU_ADD;
    endcase
  end

  always_comb begin
    alu     = ALU_ADD;
    illegal = 1'b0;
    case (cls)
      CLS_PASS: alu = ALU_PASS_B;
      CLS_R: begin
        alu = fmap;
        illegal = !(base ||
                    (alt && (f3 == 3'b000 || f3 == 3'b101)));
      end
      CLS_I: begin
        alu = fmap;
        if (f3 == 3'b001) illegal = !base;
        if (f3 == 3'b101) illegal = !(base || alt);
      end
      CLS_BR: begin
        // bits [2:1]: 00 eq/ne, 10 lt/ge, 11 ltu/geu
        unique case (f3[2:1])
          2'b00:   alu = ALU_SUB;
          2'b10:   alu = ALU_SLT;
          2'b11:   alu = ALU_SLTU;
          default: illegal = 1'b1;
        endcase
      end
      default: alu = ALU_ADD;
    endcase
    if (illegal) alu = ALU_ADD;
  end

endmodule

// File: rtl/control_unit.sv
// Main decoder for the single-cycle RV32I-subset core.
// Combinational datapath controls plus a sticky illegal flag.
module control_unit
  import cu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [1:0]  PCSrc,
  output logic [1:0]  ResultSrc,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic [4:0]  ALUControl,
  output logic [2:0]  ImmSrc,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        Negative,
  output logic        IllegalInstr
);

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  assign op = Instr[6:0];
  assign f3 = Instr[14:12];
  assign f7 = Instr[31:25];

  logic unused;
  assign unused = &{1'b0, Negative, Instr[24:15], Instr[11:7]};

  alu_cls_t cls;
  alu_op_t  alu;
  logic     alu_ill;
  logic     dec_ill;
  logic     illegal;
  logic     taken;
  ctrl_t    c;
  ctrl_t    o;

  alu_decoder u_alu_dec (
    .cls     (cls),
    .f3      (f3),
    .f7      (f7),
    .alu     (alu),
    .illegal (alu_ill)
  );

  // eq/ne compare via SUB; lt/ge via SLT result, so the sense flips
  assign taken = Zero ^ f3[0] ^ f3[2];

  always_comb begin
    c       = CTRL_DEF;
    cls     = CLS_ADD;
    dec_ill = 1'b0;
    case (op)
      OP_R: begin
        c.regwrite = 1'b1;
        cls        = CLS_R;
      end
      OP_I: begin
        c.regwrite = 1'b1;
        c.alusrc   = 1'b1;
        cls        = CLS_I;
      end
      OP_LW: begin
        c.regwrite  = 1'b1;
        c.alusrc    = 1'b1;
        c.resultsrc = RES_MEM;
        dec_ill     = (f3 != 3'b010);
      end
      OP_SW: begin
        c.memwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.immsrc   = IMM_S;
        dec_ill    = (f3 != 3'b010);
      end
      OP_BR: begin
        c.immsrc = IMM_B;
        c.pcsrc  = taken ? PC_TARGET : PC_PLUS4;
        cls      = CLS_BR;
      end
      OP_JAL: begin
        c.regwrite  = 1'b1;
        c.resultsrc = RES_PC4;
        c.immsrc    = IMM_J;
        c.pcsrc     = PC_TARGET;
      end
      OP_JALR: begin
        c.regwrite  = 1'b1;
        c.alusrc    = 1'b1;
        c.resultsrc = RES_PC4;
        c.pcsrc     = PC_ALU;
        dec_ill     = (f3 != 3'b000);
      end
      OP_LUI: begin
        c.regwrite  = 1'b1;
        c.alusrc    = 1'b1;
        c.immsrc    = IMM_U;
        c.resultsrc = RES_IMM;
        cls         = CLS_PASS;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  assign illegal = dec_ill | alu_ill;
  assign o = illegal ? CTRL_DEF : c;

  assign PCSrc      = o.pcsrc;
  assign ResultSrc  = o.resultsrc;
  assign MemWrite   = o.memwrite;
  assign ALUSrc     = o.alusrc;
  assign RegWrite   = o.regwrite;
  assign ImmSrc     = o.immsrc;
  assign ALUControl = illegal ? ALU_ADD : alu;

  always_ff @(posedge clk) begin
    if (rst) IllegalInstr <= 1'b0;
    else if (illegal) IllegalInstr <= 1'b1;
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit.
// Expected controls are hand-encoded per instruction.
module tb_control_unit;

  logic        clk;
  logic        rst;
  logic [1:0]  PCSrc;
  logic [1:0]  ResultSrc;
  logic        MemWrite;
  logic        ALUSrc;
  logic        RegWrite;
  logic [4:0]  ALUControl;
  logic [2:0]  ImmSrc;
  logic [31:0] Instr;
  logic        Zero;
  logic        Negative;
  logic        IllegalInstr;

  control_unit dut (
    .clk          (clk),
    .rst          (rst),
    .PCSrc        (PCSrc),
    .ResultSrc    (ResultSrc),
    .MemWrite     (MemWrite),
    .ALUSrc       (ALUSrc),
    .RegWrite     (RegWrite),
    .ALUControl   (ALUControl),
    .ImmSrc       (ImmSrc),
    .Instr        (Instr),
    .Zero         (Zero),
    .Negative     (Negative),
    .IllegalInstr (IllegalInstr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        zero;
    logic [14:0] exp;
    logic        ill;
  } vec_t;

  vec_t vq[$];

  function automatic logic [31:0] mk(input logic [6:0] f7,
                                     input logic [2:0] f3,
                                     input logic [6:0] op);
    mk = {f7, 5'd3, 5'd2, f3, 5'd1, op};
  endfunction

  // {PCSrc, ResultSrc, MemWrite, ALUSrc, RegWrite, ALUControl, ImmSrc}
  task automatic addv(input string nm, input logic [31:0] ins,
                      input logic z, input logic [1:0] pc,
                      input logic [1:0] rs, input logic mw,
                      input logic as, input logic rw,
                      input logic [4:0] alu, input logic [2:0] imm,
                      input logic ill);
    vec_t v;
    v.name  = nm;
    v.instr = ins;
    v.zero  = z;
    v.exp   = {pc, rs, mw, as, rw, alu, imm};
    v.ill   = ill;
    vq.push_back(v);
  endtask

  function automatic logic [14:0] obs();
    obs = {PCSrc, ResultSrc, MemWrite, ALUSrc, RegWrite,
           ALUControl, ImmSrc};
  endfunction

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    rst      = 1'b1;
    Instr    = mk(7'h00, 3'b000, 7'b0110011);
    Zero     = 1'b0;
    Negative = 1'b1;

    addv("add",   mk(7'h00,3'b000,7'b0110011),0,2'b00,2'b00,0,0,1,5'b00000,3'b000,0);
    addv("sub",   mk(7'h20,3'b000,7'b0110011),0,2'b00,2'b00,0,0,1,5'b00001,3'b000,0);
    addv("sra",   mk(7'h20,3'b101,7'b0110011),0,2'b00,2'b00,0,0,1,5'b01001,3'b000,0);
    addv("sltu",  mk(7'h00,3'b011,7'b0110011),0,2'b00,2'b00,0,0,1,5'b00110,3'b000,0);
    addv("r_bad", mk(7'h20,3'b001,7'b0110011),0,2'b00,2'b00,0,0,0,5'b00000,3'b000,1);
    addv("andi",  mk(7'h00,3'b111,7'b0010011),0,2'b00,2'b00,0,1,1,5'b00010,3'b000,0);
    addv("addi7", mk(7'h20,3'b000,7'b0010011),0,2'b00,2'b00,0,1,1,5'b00000,3'b000,0);
    addv("srai",  mk(7'h20,3'b101,7'b0010011),0,2'b00,2'b00,0,1,1,5'b01001,3'b000,0);
    addv("slli_b",mk(7'h20,3'b001,7'b0010011),0,2'b00,2'b00,0,0,0,5'b00000,3'b000,1);
    addv("lw",    mk(7'h00,3'b010,7'b0000011),0,2'b00,2'b01,0,1,1,5'b00000,3'b000,0);
    addv("lb_bad",mk(7'h00,3'b000,7'b0000011),0,2'b00,2'b00,0,0,0,5'b00000,3'b000,1);
    addv("sw",    mk(7'h00,3'b010,7'b0100011),0,2'b00,2'b00,1,1,0,5'b00000,3'b001,0);
    addv("beq_z1",mk(7'h00,3'b000,7'b1100011),1,2'b01,2'b00,0,0,0,5'b00001,3'b010,0);
    addv("beq_z0",mk(7'h00,3'b000,7'b1100011),0,2'b00,2'b00,0,0,0,5'b00001,3'b010,0);
    addv("bne_z0",mk(7'h00,3'b001,7'b1100011),0,2'b01,2'b00,0,0,0,5'b00001,3'b010,0);
    addv("blt_z1",mk(7'h00,3'b100,7'b1100011),1,2'b00,2'b00,0,0,0,5'b00101,3'b010,0);
    addv("bge_z1",mk(7'h00,3'b101,7'b1100011),1,2'b01,2'b00,0,0,0,5'b00101,3'b010,0);
    addv("bltu0", mk(7'h00,3'b110,7'b1100011),0,2'b01,2'b00,0,0,0,5'b00110,3'b010,0);
    addv("bgeu0", mk(7'h00,3'b111,7'b1100011),0,2'b00,2'b00,0,0,0,5'b00110,3'b010,0);
    addv("br_bad",mk(7'h00,3'b010,7'b1100011),1,2'b00,2'b00,0,0,0,5'b00000,3'b000,1);
    addv("jal",   mk(7'h15,3'b110,7'b1101111),0,2'b01,2'b10,0,0,1,5'b00000,3'b011,0);
    addv("jalr",  mk(7'h00,3'b000,7'b1100111),0,2'b10,2'b10,0,1,1,5'b00000,3'b000,0);
    addv("lui",   mk(7'h7f,3'b101,7'b0110111),0,2'b00,2'b11,0,1,1,5'b01010,3'b100,0);
    addv("auipc", mk(7'h00,3'b000,7'b0010111),0,2'b00,2'b00,0,0,0,5'b00000,3'b000,1);

    // controls are combinational and valid while reset is held
    Instr = mk(7'h00, 3'b010, 7'b0100011);
    #1;
    check("sw_in_rst", obs(), 15'b00_00_1_1_0_00000_001);
    @(posedge clk);
    #1;
    check("rst_flag", IllegalInstr, 1'b0);

    foreach (vq[i]) begin
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst   = 1'b0;
      Instr = vq[i].instr;
      Zero  = vq[i].zero;
      #1;
      check(vq[i].name, obs(), vq[i].exp);
      @(posedge clk);
      #1;
      check({vq[i].name, "_flag"}, IllegalInstr, vq[i].ill);
    end

    // sticky flag: set by zero word, held across a legal add
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    Instr = 32'h0000_0000;
    #1;
    check("zero_rw", RegWrite, 1'b0);
    check("zero_mw", MemWrite, 1'b0);
    check("zero_pre", IllegalInstr, 1'b0);
    @(posedge clk);
    #1;
    check("zero_set", IllegalInstr, 1'b1);
    @(negedge clk);
    Instr = mk(7'h00, 3'b000, 7'b0110011);
    @(posedge clk);
    #1;
    check("sticky1", IllegalInstr, 1'b1);
    @(posedge clk);
    #1;
    check("sticky2", IllegalInstr, 1'b1);
    // reset wins over a simultaneous illegal instruction
    @(negedge clk);
    rst   = 1'b1;
    Instr = 32'h0000_0000;
    @(posedge clk);
    #1;
    check("rst_prio", IllegalInstr, 1'b0);
    @(negedge clk);
    rst   = 1'b0;
    Instr = mk(7'h00, 3'b000, 7'b0110011);
    @(posedge clk);
    #1;
    check("clr_hold", IllegalInstr, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Main decoder plus ALU decoder for a single-cycle RV32I-subset core.
- Takes the fetched 32-bit instruction and the ALU flags, and drives datapath selects and write enables.
- All datapath controls are combinational and valid in the same cycle as Instr.
- A registered sticky illegal-instruction flag is the only clocked state.

Parameters:
- none

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- PCSrc  out  2  next-PC select: 00 PC+4, 01 PC+ImmExt, 10 ALU result (jalr).
- ResultSrc  out  2  writeback select: 00 ALU, 01 data memory, 10 PC+4, 11 ImmExt.
- MemWrite  out  1  data memory write enable.
- ALUSrc  out  1  ALU operand B select: 0 rs2, 1 ImmExt.
- RegWrite  out  1  register file write enable.
- ALUControl  out  5  ALU operation code (see Behaviour).
- ImmSrc  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
- Instr  in  32  current instruction.
- Zero  in  1  ALU result == 0.
- Negative  in  1  ALU result bit 31. Accepted but not used in any decision.
- IllegalInstr  out  1  sticky flag, set after any clock edge that sees an undecodable instruction.

Behaviour:
- Fields decoded: op = Instr[6:0], f3 = Instr[14:12], f7 = Instr[31:25].
- ALUControl codes: 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 XOR, 00101 SLT, 00110 SLTU, 00111 SLL, 01000 SRL, 01001 SRA, 01010 PASS_B.
- Defaults for every output not listed below: PCSrc 00, ResultSrc 00, MemWrite 0, ALUSrc 0, RegWrite 0, ALUControl ADD, ImmSrc 000.
- R-type (0110011): RegWrite 1.
  - ALU op from f3: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
  - f7 must be 0000000, or 0100000 only with f3=000 (SUB) or f3=101 (SRA); any other f7 is illegal.
- I-ALU (0010011): RegWrite 1, ALUSrc 1, ImmSrc 000.
  - Same f3 map as R-type, but f3=000 is always ADD.
  - f3=001 requires f7=0000000; f3=101 requires f7 0000000 (SRL) or 0100000 (SRA); otherwise illegal.
- lw (0000011, f3=010): RegWrite 1, ALUSrc 1, ResultSrc 01, ALU ADD. Other f3 values are illegal.
- sw (0100011, f3=010): MemWrite 1, ALUSrc 1, ImmSrc 001, ALU ADD. Other f3 values are illegal.
- Branch (1100011): ImmSrc 010, ALUSrc 0.
  - beq: ALU SUB, taken = Zero.
  - bne: ALU SUB, taken = !Zero.
  - blt: ALU SLT, taken = !Zero.
  - bge: ALU SLT, taken = Zero.
  - bltu: ALU SLTU, taken = !Zero.
  - bgeu: ALU SLTU, taken = Zero.
  - PCSrc = 01 if taken, else 00. f3 values 010 and 011 are illegal.
- jal (1101111): RegWrite 1, ResultSrc 10, ImmSrc 011, PCSrc 01.
- jalr (1100111, f3=000): RegWrite 1, ALUSrc 1, ResultSrc 10, ImmSrc 000, ALU ADD, PCSrc 10.
- lui (0110111): RegWrite 1, ALUSrc 1, ImmSrc 100, ALU PASS_B, ResultSrc 11.
- Any other opcode (including auipc, fence, system) or illegal field combination:
  - all defaults, which guarantees RegWrite = MemWrite = 0 and PCSrc = 00;
  - internal illegal = 1.
- IllegalInstr register:
  - rst=1 at a clock edge clears it to 0, with priority over setting;
  - otherwise it is set to 1 at any edge where illegal = 1, and holds until the next reset.
- Combinational outputs do not depend on clk or rst; they are valid during reset.
- The block has no other state and no X propagation: every case has a full default.

Decomposition:
- Shared package cu_pkg holds:
  - opcode constants;
  - ALUControl enum (alu_op_t);
  - PCSrc, ResultSrc and ImmSrc enums.
- One natural sub-module, alu_decoder: maps (op class, f3, f7) to ALUControl plus an illegal bit.
- The top level holds the main decoder, the branch-taken logic and the IllegalInstr register.

Test Plan:
- add (op 0110011, f3 000, f7 0) -> PCSrc 00, ResultSrc 00, MemWrite 0, ALUSrc 0, RegWrite 1, ALUControl 00000, ImmSrc 000.
- andi (op 0010011, f3 111) -> PCSrc 00, ResultSrc 00, MemWrite 0, ALUSrc 1, RegWrite 1, ALUControl 00010, ImmSrc 000.
- sw (op 0100011, f3 010) -> MemWrite 1, ALUSrc 1, RegWrite 0, ImmSrc 001, ALUControl 00000.
- beq with Zero=1 -> PCSrc 01, RegWrite 0, ALUControl 00001, ImmSrc 010. beq with Zero=0 -> PCSrc 00. bge with Zero=1 -> PCSrc 01.
- jal -> PCSrc 01, ResultSrc 10, RegWrite 1, ImmSrc 011. lui -> PCSrc 00, ResultSrc 11, ALUSrc 1, RegWrite 1, ALUControl 01010, ImmSrc 100.
- Illegal instruction and reset:
  - rst, then Instr=0x00000000 (illegal opcode) -> RegWrite/MemWrite 0, IllegalInstr 1 after the next edge;
  - IllegalInstr stays 1 with a valid add applied;
  - rst=1 at an edge -> IllegalInstr 0.
